// File: rtl/difftest_trigger_pkg.sv
// difftest_trigger_pkg: shared CSR addresses, width and FSM states for the trigger-CSR difftest source
package difftest_trigger_pkg;
    localparam int XLEN = 64;
    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1 = 12'h7A1;
    localparam logic [11:0] CSR_TINFO = 12'h7A4;
    typedef enum logic {CLEAN, PENDING} trig_state_e;
endpackage

// File: rtl/trigger_csr_shadow.sv
// trigger_csr_shadow: shadow tselect/tdata1 state with post-write view and change detection
module trigger_csr_shadow
    import difftest_trigger_pkg::*;
#(
    parameter int NUM_TRIGGERS = 4,
    parameter logic [XLEN-1:0] TDATA1_WMASK = '1,
    localparam int TW = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wen,
    input  logic [11:0]     waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [TW-1:0]   tselect_nxt,
    output logic [XLEN-1:0] tdata1_nxt,
    output logic            changed
);
    logic [TW-1:0]   tselect;
    logic [XLEN-1:0] tdata1 [NUM_TRIGGERS];
    logic            sel_wr;
    logic            data_wr;
    logic [XLEN-1:0] wmasked;
    assign sel_wr      = wen && waddr == CSR_TSELECT && wdata < XLEN'(NUM_TRIGGERS);
    assign data_wr     = wen && waddr == CSR_TDATA1;
    assign wmasked     = wdata & TDATA1_WMASK;
    assign tselect_nxt = sel_wr ? wdata[TW-1:0] : tselect;
    // only one address per cycle, so a tdata1 write always targets the old tselect
    assign tdata1_nxt  = data_wr ? wmasked : tdata1[tselect_nxt];
    assign changed     = (sel_wr && tselect_nxt != tselect) || (data_wr && wmasked != tdata1[tselect]);
    always_ff @(posedge clock) begin
        if (reset) begin
            tselect <= '0;
            for (int i = 0; i < NUM_TRIGGERS; i++) tdata1[i] <= '0;
        end else begin
            tselect <= tselect_nxt;
            if (data_wr) tdata1[tselect] <= wmasked;
        end
    end
endmodule

// File: rtl/difftest_trigger_csr_source.sv
// difftest_trigger_csr_source: snapshots trigger CSR state to the difftest sink at commit boundaries
module difftest_trigger_csr_source
    import difftest_trigger_pkg::*;
#(
    parameter int NUM_TRIGGERS = 4,
    parameter logic [XLEN-1:0] TINFO_VALUE = 64'h0000_0000_0000_0044,
    parameter logic [XLEN-1:0] TDATA1_WMASK = 64'hFFFF_FFFF_FFFF_FFFF,
    localparam int TW = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      io_coreid,
    input  logic            io_csr_wen,
    input  logic [11:0]     io_csr_waddr,
    input  logic [XLEN-1:0] io_csr_wdata,
    input  logic            io_commit_valid,
    input  logic            io_force,
    output logic            io_out_enable,
    output logic [XLEN-1:0] io_out_tselect,
    output logic [XLEN-1:0] io_out_tdata1,
    output logic [XLEN-1:0] io_out_tinfo,
    output logic [7:0]      io_out_coreid
);
    trig_state_e     state;
    trig_state_e     state_nxt;
    logic [TW-1:0]   tselect_nxt;
    logic [XLEN-1:0] tdata1_nxt;
    logic            changed;
    logic            fire;
    trigger_csr_shadow #(
        .NUM_TRIGGERS(NUM_TRIGGERS),
        .TDATA1_WMASK(TDATA1_WMASK)
    ) u_shadow (
        .clock      (clock),
        .reset      (reset),
        .wen        (io_csr_wen),
        .waddr      (io_csr_waddr),
        .wdata      (io_csr_wdata),
        .tselect_nxt(tselect_nxt),
        .tdata1_nxt (tdata1_nxt),
        .changed    (changed)
    );
    assign fire = state == PENDING && io_commit_valid;
    // PENDING stands for dirty or a sticky force; a snapshot consumes both
    always_comb begin
        state_nxt = CLEAN;
        state_nxt = fire ? CLEAN : (state == PENDING || changed || io_force) ? PENDING : CLEAN;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= PENDING;
            io_out_enable  <= 1'b0;
            io_out_tselect <= '0;
            io_out_tdata1  <= '0;
            io_out_tinfo   <= '0;
            io_out_coreid  <= '0;
        end else begin
            state         <= state_nxt;
            io_out_enable <= fire;
            if (fire) begin
                io_out_tselect <= XLEN'(tselect_nxt);
                io_out_tdata1  <= tdata1_nxt;
                io_out_tinfo   <= TINFO_VALUE;
                io_out_coreid  <= io_coreid;
            end
        end
    end
endmodule

// File: tb/tb_difftest_trigger_csr_source.sv
// tb_difftest_trigger_csr_source: directed plus random checks against a rule-level model
module tb_difftest_trigger_csr_source;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  io_coreid = '0;
    logic        io_csr_wen = 1'b0;
    logic [11:0] io_csr_waddr = '0;
    logic [63:0] io_csr_wdata = '0;
    logic        io_commit_valid = 1'b0;
    logic        io_force = 1'b0;
    logic        io_out_enable;
    logic [63:0] io_out_tselect;
    logic [63:0] io_out_tdata1;
    logic [63:0] io_out_tinfo;
    logic [7:0]  io_out_coreid;

    int total = 0;
    int bad = 0;

    logic [63:0] m_td [4];
    int          m_tsel;
    bit          m_pend;
    logic        e_en;
    logic [63:0] e_tsel, e_td, e_tinfo;
    logic [7:0]  e_core;

    difftest_trigger_csr_source dut (
        .clock          (clock),
        .reset          (reset),
        .io_coreid      (io_coreid),
        .io_csr_wen     (io_csr_wen),
        .io_csr_waddr   (io_csr_waddr),
        .io_csr_wdata   (io_csr_wdata),
        .io_commit_valid(io_commit_valid),
        .io_force       (io_force),
        .io_out_enable  (io_out_enable),
        .io_out_tselect (io_out_tselect),
        .io_out_tdata1  (io_out_tdata1),
        .io_out_tinfo   (io_out_tinfo),
        .io_out_coreid  (io_out_coreid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("enable", 64'(io_out_enable), 64'(e_en));
        chk("tselect", io_out_tselect, e_tsel);
        chk("tdata1", io_out_tdata1, e_td);
        chk("tinfo", io_out_tinfo, e_tinfo);
        chk("coreid", 64'(io_out_coreid), 64'(e_core));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_td[i] = '0;
        m_tsel = 0;
        m_pend = 1'b1;
        e_en = 1'b0;
        e_tsel = '0;
        e_td = '0;
        e_tinfo = '0;
        e_core = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        io_csr_wen = 1'b0;
        io_commit_valid = 1'b0;
        io_force = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        chk_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input logic wen, input logic [11:0] addr, input logic [63:0] data,
                        input logic commit, input logic frc, input logic [7:0] core);
        bit fire;
        bit chg;
        @(negedge clock);
        io_csr_wen = wen;
        io_csr_waddr = addr;
        io_csr_wdata = data;
        io_commit_valid = commit;
        io_force = frc;
        io_coreid = core;
        fire = m_pend && commit;
        chg = 1'b0;
        if (wen && addr == 12'h7A0 && data < 4) begin
            chg = (data != 64'(m_tsel));
            m_tsel = int'(data);
        end else if (wen && addr == 12'h7A1) begin
            chg = (m_td[m_tsel] != data);
            m_td[m_tsel] = data;
        end
        e_en = fire;
        if (fire) begin
            e_tsel = 64'(m_tsel);
            e_td = m_td[m_tsel];
            e_tinfo = 64'h44;
            e_core = core;
            m_pend = 1'b0;
        end else begin
            m_pend = m_pend || chg || frc;
        end
        @(posedge clock);
        #1;
        chk_all();
    endtask

    initial begin
        model_reset();
        do_reset();
        step(0, 12'h000, 0, 0, 0, 8'h00);
        step(0, 12'h000, 0, 0, 0, 8'h00);
        step(0, 12'h000, 0, 1, 0, 8'h05);
        chk("first_tinfo", io_out_tinfo, 64'h44);
        step(0, 12'h000, 0, 1, 0, 8'h05);
        step(0, 12'h000, 0, 1, 0, 8'h05);
        step(1, 12'h7A0, 2, 0, 0, 8'h05);
        step(1, 12'h7A1, 64'h1234, 0, 0, 8'h05);
        step(0, 12'h000, 0, 1, 0, 8'h06);
        chk("sel2_td", io_out_tdata1, 64'h1234);
        step(1, 12'h7A0, 0, 0, 0, 8'h06);
        step(0, 12'h000, 0, 1, 0, 8'h06);
        step(1, 12'h7A0, 7, 0, 0, 8'h06);
        step(0, 12'h000, 0, 1, 0, 8'h06);
        step(1, 12'h7A4, 64'hFF, 0, 0, 8'h06);
        step(0, 12'h000, 0, 1, 0, 8'h06);
        step(1, 12'h7A1, 64'hABCD, 1, 0, 8'h07);
        step(0, 12'h000, 0, 1, 0, 8'h07);
        chk("same_cycle_td", io_out_tdata1, 64'hABCD);
        step(1, 12'h7A1, 64'hABCD, 0, 0, 8'h07);
        step(0, 12'h000, 0, 1, 0, 8'h07);
        step(0, 12'h000, 0, 0, 1, 8'h07);
        step(0, 12'h000, 0, 0, 0, 8'h07);
        step(0, 12'h000, 0, 1, 0, 8'h08);
        step(0, 12'h000, 0, 1, 0, 8'h08);
        step(1, 12'h7A1, 64'h5555, 1, 0, 8'h09);
        step(1, 12'h7A1, 64'h6666, 0, 0, 8'h09);
        step(0, 12'h000, 0, 1, 0, 8'h09);
        step(1, 12'h7A1, 64'h7777, 0, 0, 8'h09);
        do_reset();
        step(0, 12'h000, 0, 1, 0, 8'h0A);
        chk("post_reset_td", io_out_tdata1, 64'h0);
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a;
            logic [63:0] d;
            case ($urandom_range(0, 3))
                0: a = 12'h7A0;
                1: a = 12'h7A1;
                2: a = 12'h7A4;
                default: a = 12'h7FF;
            endcase
            d = ($urandom_range(0, 9) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 1) == 1, a, d, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0, 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
